// File: rtl/systolic_feed_controller.sv
// Sequences one tile: N unified-buffer row reads, staging strobes one cycle later,
// accumulator writes ACC_LAT cycles after staging, then a one-cycle done pulse.
module systolic_feed_controller #(
    parameter int ARRAY_DIM = 32,
    parameter int ADDR_W    = 10,
    parameter int ROWS_W    = 10,
    parameter int ACC_LAT   = 2 * ARRAY_DIM
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ROWS_W-1:0] num_rows_i,
    input  logic [ADDR_W-1:0] ub_base_i,
    input  logic [ADDR_W-1:0] acc_base_i,
    input  logic              weights_rdy_i,
    output logic              ub_rd_en_o,
    output logic [ADDR_W-1:0] ub_rd_addr_o,
    output logic              stage_read_o,
    output logic              acc_wr_en_o,
    output logic [ADDR_W-1:0] acc_wr_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_W,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ROWS_W-1:0] n_q, n_d;
    logic [ROWS_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ROWS_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] ub_base_q, ub_base_d;
    logic [ADDR_W-1:0] acc_base_q, acc_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              stage_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ACC_LAT-1:0] pipe_q;
    logic [ACC_LAT:0]   chain;
    logic               wr_next;

    // chain[i] is the staging strobe delayed i cycles; the top bit is the write strobe itself.
    assign chain   = {pipe_q, stage_q};
    assign wr_next = chain[ACC_LAT-1];

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rd_cnt_d   = rd_cnt_q;
        ub_base_d  = ub_base_q;
        acc_base_d = acc_base_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = '0;
        wr_cnt_d   = wr_next ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_addr_d  = wr_next ? acc_base_q + ADDR_W'(wr_cnt_q) : '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d        = num_rows_i;
                    ub_base_d  = ub_base_i;
                    acc_base_d = acc_base_i;
                    wr_cnt_d   = '0;
                    if (num_rows_i == '0) begin
                        state_d = S_DONE;
                    end else if (weights_rdy_i) begin
                        state_d   = S_FEED;
                        rd_en_d   = 1'b1;
                        rd_addr_d = ub_base_i;
                        rd_cnt_d  = ROWS_W'(1);
                    end else begin
                        state_d = S_WAIT_W;
                    end
                end
            end
            S_WAIT_W: begin
                if (weights_rdy_i) begin
                    state_d   = S_FEED;
                    rd_en_d   = 1'b1;
                    rd_addr_d = ub_base_q;
                    rd_cnt_d  = ROWS_W'(1);
                end
            end
            S_FEED: begin
                if (rd_cnt_q == n_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = ub_base_q + ADDR_W'(rd_cnt_q);
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Only the write being issued this cycle may remain in flight.
                if (chain[ACC_LAT-1:0] == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_WAIT_W) || (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            ub_base_q  <= '0;
            acc_base_q <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            stage_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            ub_base_q  <= ub_base_d;
            acc_base_q <= acc_base_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_en_q    <= rd_en_d;
            stage_q    <= rd_en_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pipe_q     <= chain[ACC_LAT-1:0];
        end
    end

    assign ub_rd_en_o    = rd_en_q;
    assign ub_rd_addr_o  = rd_addr_q;
    assign stage_read_o  = stage_q;
    assign acc_wr_en_o   = pipe_q[ACC_LAT-1];
    assign acc_wr_addr_o = wr_addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
